// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, STORE, LOAD_REQ, LOAD_CAP, RESP} lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Unsigned widths have no store form.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: is_illegal = 1'b0;
      F3_BU, F3_HU:     is_illegal = we;
      default:          is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic is_misalign(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: is_misalign = off[0];
      F3_W:        is_misalign = (off != 2'b00);
      default:     is_misalign = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane enables/replicated data and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rd,
  output logic [NBYTES-1:0] wen,
  output logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   ld_data
);

  logic [XLEN-1:0] shift;

  always_comb begin
    wen = 4'b1111;
    wd  = wdata;
    case (funct3)
      F3_B: begin
        wen = 4'b0001 << off;
        wd  = {4{wdata[7:0]}};
      end
      F3_H: begin
        wen = 4'b0011 << off;
        wd  = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shift   = rd >> {off, 3'b000};
    ld_data = rd;
    case (funct3)
      F3_B:  ld_data = {{24{shift[7]}}, shift[7:0]};
      F3_BU: ld_data = {24'h0, shift[7:0]};
      F3_H:  ld_data = {{16{shift[15]}}, shift[15:0]};
      F3_HU: ld_data = {16'h0, shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sole master of the data memory port.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal,
  output logic [31:0] o_mem_Addr,
  output logic [31:0] o_mem_Wd,
  output logic [3:0]  o_mem_Wen,
  output logic        o_mem_Ren,
  input  logic [31:0] i_mem_Rd
);

  lsu_state_e      state;
  lsu_req_t        req;
  logic            ill, mis;
  logic [3:0]      al_wen;
  logic [31:0]     al_wd, al_ld;

  assign ill = is_illegal(i_req_we, i_funct3);
  assign mis = !ill && is_misalign(i_funct3, i_addr[1:0]);

  lsu_align u_align (
    .funct3  (req.funct3),
    .off     (req.addr[1:0]),
    .wdata   (req.wdata),
    .rd      (i_mem_Rd),
    .wen     (al_wen),
    .wd      (al_wd),
    .ld_data (al_ld)
  );

  // Memory strobes come straight from the registered state and latched request.
  always_comb begin
    o_mem_Addr = '0;
    o_mem_Wd   = '0;
    o_mem_Wen  = '0;
    o_mem_Ren  = 1'b0;
    if (state == STORE && req.we) begin
      o_mem_Addr = {req.addr[31:2], 2'b00};
      o_mem_Wd   = al_wd;
      o_mem_Wen  = al_wen;
    end else if (state == LOAD_REQ) begin
      o_mem_Addr = {req.addr[31:2], 2'b00};
      o_mem_Ren  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= IDLE;
      req          <= '0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_rdata      <= '0;
      o_misalign   <= 1'b0;
      o_illegal    <= 1'b0;
    end else begin
      o_resp_valid <= 1'b0;
      case (state)
        IDLE: if (i_req_valid) begin
          req         <= '{we: i_req_we, funct3: i_funct3, addr: i_addr, wdata: i_wdata};
          o_req_ready <= 1'b0;
          if (ill || mis) begin
            state        <= RESP;
            o_resp_valid <= 1'b1;
            o_rdata      <= '0;
            o_illegal    <= ill;
            o_misalign   <= mis;
          end else begin
            state <= i_req_we ? STORE : LOAD_REQ;
          end
        end
        STORE: begin
          state        <= RESP;
          o_resp_valid <= 1'b1;
          o_rdata      <= '0;
          o_illegal    <= 1'b0;
          o_misalign   <= 1'b0;
        end
        LOAD_REQ: state <= LOAD_CAP;
        LOAD_CAP: begin
          state        <= RESP;
          o_resp_valid <= 1'b1;
          o_rdata      <= al_ld;
          o_illegal    <= 1'b0;
          o_misalign   <= 1'b0;
        end
        RESP: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
